// File: rtl/bulk_stream_pkg.sv
// rtl/bulk_stream_pkg.sv - shared constants and payload type for the bulk stream receiver
package bulk_stream_pkg;

    localparam int STREAM_WIDTH   = 16;
    localparam int RX_FIFO_DEPTH  = 4;
    localparam int DROP_CNT_WIDTH = 8;

    typedef logic [STREAM_WIDTH-1:0] stream_value_t;

endpackage

// File: rtl/bulk_receiver_fifo.sv
// rtl/bulk_receiver_fifo.sv - receive FIFO storage, wrapping pointers and occupancy count
module bulk_receiver_fifo
    import bulk_stream_pkg::*;
#(
    parameter int WIDTH = STREAM_WIDTH,
    parameter int DEPTH = RX_FIFO_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_value,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_value,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             pop_ok;

    // Popping an empty FIFO is ignored so the count can never underflow.
    assign pop_ok = pop && (count != '0);

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_value;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_value = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/bulk_stream_receiver.sv
// rtl/bulk_stream_receiver.sv - value/enable stream to valid/ready bridge with overflow accounting
module bulk_stream_receiver
    import bulk_stream_pkg::*;
#(
    parameter int WIDTH = STREAM_WIDTH,
    parameter int DEPTH = RX_FIFO_DEPTH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          in_value,
    input  logic                      in_enable,
    output logic [WIDTH-1:0]          out_value,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic [DROP_CNT_WIDTH-1:0] drop_count,
    input  logic                      clear_overflow
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]             FULL_COUNT = CW'(DEPTH);
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX   = '1;

    logic full;
    logic pop;
    logic push;
    logic drop;

    assign out_valid = (count != '0);
    assign full      = (count == FULL_COUNT);
    assign pop       = out_valid && out_ready;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts the beat.
    assign push      = in_enable && (!full || pop);
    assign drop      = in_enable && full && !pop;

    bulk_receiver_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_value (in_value),
        .pop        (pop),
        .head_value (out_value),
        .count      (count)
    );

    // A drop coinciding with a clear counts as the first drop after the clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear_overflow) begin
                drop_count <= DROP_CNT_WIDTH'(1);
            end else if (drop_count != DROP_MAX) begin
                drop_count <= drop_count + DROP_CNT_WIDTH'(1);
            end
        end else if (clear_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule

// File: tb/tb_bulk_stream_receiver.sv
// tb/tb_bulk_stream_receiver.sv - directed self-checking bench for bulk_stream_receiver
module tb_bulk_stream_receiver;
    import bulk_stream_pkg::*;

    logic          clock;
    logic          reset;
    stream_value_t in_value;
    logic          in_enable;
    stream_value_t out_value;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    count;
    logic          overflow;
    logic [7:0]    drop_count;
    logic          clear_overflow;

    int checks;
    int failures;

    bulk_stream_receiver #(
        .WIDTH (STREAM_WIDTH),
        .DEPTH (RX_FIFO_DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .in_value       (in_value),
        .in_enable      (in_enable),
        .out_value      (out_value),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .count          (count),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .clear_overflow (clear_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".valid"}, 32'(out_valid), 32'd0);
        check({tag, ".value"}, 32'(out_value), 32'd0);
        check({tag, ".count"}, 32'(count), 32'd0);
        check({tag, ".ovf"}, 32'(overflow), 32'd0);
        check({tag, ".drops"}, 32'(drop_count), 32'd0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        in_value = '0;
        in_enable = 1'b0;
        out_ready = 1'b0;
        clear_overflow = 1'b0;
        step();
        step();
        check_idle("reset");
        reset = 1'b0;

        // Basic capture
        in_value = 16'h1234;
        in_enable = 1'b1;
        step();
        in_enable = 1'b0;
        in_value = 16'hFFFF;
        check("cap.valid", 32'(out_valid), 32'd1);
        check("cap.value", 32'(out_value), 32'h1234);
        check("cap.count", 32'(count), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("cap.pop_valid", 32'(out_valid), 32'd0);
        check("cap.pop_value", 32'(out_value), 32'd0);
        check("cap.pop_count", 32'(count), 32'd0);

        // Fill and overflow
        for (int i = 1; i <= 6; i++) begin
            in_value = 16'(i);
            in_enable = 1'b1;
            step();
        end
        in_enable = 1'b0;
        check("fill.count", 32'(count), 32'd4);
        check("fill.ovf", 32'(overflow), 32'd1);
        check("fill.drops", 32'(drop_count), 32'd2);
        for (int k = 1; k <= 4; k++) begin
            check("fill.drain", 32'(out_value), 32'(k));
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        check("fill.empty", 32'(count), 32'd0);
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        check("fill.clr_ovf", 32'(overflow), 32'd0);
        check("fill.clr_drops", 32'(drop_count), 32'd0);

        // Full with simultaneous pop
        for (int i = 0; i < 4; i++) begin
            in_value = 16'hA0 + 16'(i);
            in_enable = 1'b1;
            step();
        end
        check("fp.full", 32'(count), 32'd4);
        in_value = 16'hA4;
        out_ready = 1'b1;
        step();
        in_enable = 1'b0;
        out_ready = 1'b0;
        check("fp.count", 32'(count), 32'd4);
        check("fp.ovf", 32'(overflow), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            check("fp.drain", 32'(out_value), 32'hA0 + 32'(k));
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        check("fp.empty", 32'(count), 32'd0);

        // Streaming through wrap-around
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_value = 16'(i);
            in_enable = 1'b1;
            step();
            check("str.value", 32'(out_value), 32'(i));
            check("str.count", 32'(count), 32'd1);
        end
        in_enable = 1'b0;
        step();
        out_ready = 1'b0;
        check("str.empty", 32'(count), 32'd0);
        check("str.ovf", 32'(overflow), 32'd0);

        // Saturation, clear alone, clear with drop
        in_enable = 1'b1;
        for (int i = 0; i < 304; i++) begin
            in_value = 16'h5000 + 16'(i);
            step();
        end
        in_enable = 1'b0;
        check("sat.drops", 32'(drop_count), 32'd255);
        check("sat.ovf", 32'(overflow), 32'd1);
        check("sat.head", 32'(out_value), 32'h5000);
        clear_overflow = 1'b1;
        step();
        check("clr.ovf", 32'(overflow), 32'd0);
        check("clr.drops", 32'(drop_count), 32'd0);
        in_enable = 1'b1;
        step();
        in_enable = 1'b0;
        clear_overflow = 1'b0;
        check("clrdrop.ovf", 32'(overflow), 32'd1);
        check("clrdrop.drops", 32'(drop_count), 32'd1);

        // Reset mid-operation
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("rst.pre_count", 32'(count), 32'd3);
        check("rst.pre_ovf", 32'(overflow), 32'd1);
        reset = 1'b1;
        in_enable = 1'b1;
        in_value = 16'hBEEF;
        step();
        reset = 1'b0;
        in_enable = 1'b0;
        check_idle("rst");
        step();
        check_idle("rst.after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bulk_stream_receiver.md
# bulk_stream_receiver

Receiving end of the 16-bit value/enable stream carried through the bulk-connected component chain. Every beat presented with `in_enable` high is captured into a small FIFO and re-presented on a valid/ready output, so a downstream consumer can apply backpressure. The upstream chain has no backpressure, so beats that arrive while the FIFO is full are dropped and reported through a sticky overflow flag and a saturating drop counter.

## Interface
- `WIDTH`, 16: payload width; matches the stream's value field.
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `in_value`  in  WIDTH  stream payload.
- `in_enable`  in  1  beat-present qualifier; one beat per cycle while high.
- `out_value`  out  WIDTH  head-of-FIFO payload; 0 when empty.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts the head this cycle.
- `count`  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky; a beat has been dropped since the last clear.
- `drop_count`  out  8  dropped beats; saturates at 255.
- `clear_overflow`  in  1  clears `overflow` and `drop_count`.

## Operation
- Pop when `out_valid && out_ready`; the head advances and `count` decrements.
- Push when `in_enable` is high and either `count < DEPTH` or a pop occurs in the same cycle. A full FIFO with a simultaneous pop accepts the new beat, and `count` stays at DEPTH.
- Drop when `in_enable` is high, `count == DEPTH` and there is no pop. The beat is discarded, `overflow` is set to 1, and `drop_count` increments unless it is already 255.
- A push and pop in the same cycle leave `count` unchanged.
- Order is strict FIFO. No reordering. No duplication.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full and empty are decided from `count`, never from pointer equality.
- `clear_overflow`:
  - Clears `overflow` and resets `drop_count` to 0.
  - If a drop occurs in the same cycle, the drop wins: `overflow` = 1 and `drop_count` = 1.
- `out_value` is forced to 0 whenever `count == 0`.
- `out_ready` while empty is ignored, with no underflow.
- `in_value` is ignored when `in_enable` is low.

## Timing
- Reset values:
  - `out_value` = 0, `out_valid` = 0, `count` = 0, `overflow` = 0, `drop_count` = 0.
  - Read and write pointers = 0.
  - Storage contents are don't-care.
- Latency is 1 cycle. A beat pushed at edge N is visible on `out_value` with `out_valid` high after edge N; there is no combinational fall-through from `in_*` to `out_*`.
- `out_valid`, `out_value`, `count`, `overflow` and `drop_count` are registered or derived only from registers. There is no combinational path from `out_ready`.
- Reset asserted mid-stream discards all queued beats. The cycle after reset deasserts behaves as the first cycle after power-up. A beat with `in_enable` high in the same cycle as `reset` is not captured.

## Structure
- Shared package `bulk_stream_pkg` holds:
  - `STREAM_WIDTH` = 16.
  - `RX_FIFO_DEPTH` = 4.
  - `DROP_CNT_WIDTH` = 8.
  - A payload typedef `stream_value_t` (WIDTH bits).
- One sub-module, `bulk_receiver_fifo`: storage array, pointers and `count`, with push/pop inputs.
- Top level `bulk_stream_receiver` owns the push/drop decision, the overflow flag and the drop counter.

## Test plan
- **Basic capture.** After reset, apply 0x1234 with enable for 1 cycle and hold `out_ready` = 0. Next cycle `out_valid` = 1, `out_value` = 0x1234 and `count` = 1. Pulse `out_ready` for 1 cycle: the cycle after, `out_valid` = 0, `out_value` = 0 and `count` = 0.
- **Fill and overflow.** Apply 6 consecutive beats 0x0001..0x0006 with `out_ready` = 0. Then `count` = 4, `overflow` = 1, `drop_count` = 2. Draining yields 0x0001, 0x0002, 0x0003, 0x0004 in order.
- **Full with simultaneous pop.** With the FIFO full of 0xA0..0xA3, apply beat 0xA4 with `out_ready` = 1. Then `count` = 4, `overflow` stays 0, and the drain order is 0xA1, 0xA2, 0xA3, 0xA4.
- **Streaming and wrap-around.** Hold `out_ready` = 1 with enable high for 20 cycles carrying 0..19. The output sequence is 0..19, each 1 cycle late, `count` never exceeds 1, and `overflow` stays 0.
- **Clear vs drop and saturation.** Force 300 drops: `drop_count` = 255. Assert `clear_overflow` alone: next cycle `overflow` = 0 and `drop_count` = 0. Assert `clear_overflow` together with a drop: `overflow` = 1 and `drop_count` = 1.
- **Reset mid-operation.** With 3 beats queued and `overflow` = 1, assert `reset` for 1 cycle while `in_enable` = 1. Next cycle all outputs = 0 and the beat presented during reset is absent.
